// File: rtl/ex_stage_pipe_if.sv
// Execute-stage bus: upstream operation handshake, downstream result handshake,
// flush and the exported flag register.
interface ex_stage_pipe_if #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 10
);
  logic              iValid;
  logic              oReady;
  logic [DATA_W-1:0] iAcumA;
  logic [DATA_W-1:0] iAcumB;
  logic [DATA_W-1:0] iConst;
  logic [1:0]        iSelMux;
  logic [3:0]        iOp;
  logic [ADDR_W-1:0] iBranchDir;
  logic              iFlush;
  logic              iReady;
  logic              oValid;
  logic [DATA_W-1:0] oAluData;
  logic              oBranchTaken;
  logic [ADDR_W-1:0] oBranchDir;
  logic [2:0]        oFlags;

  // Stage side
  modport slave (
    input  iValid, iAcumA, iAcumB, iConst, iSelMux, iOp, iBranchDir, iFlush, iReady,
    output oReady, oValid, oAluData, oBranchTaken, oBranchDir, oFlags
  );

  // Pipeline / environment side
  modport master (
    output iValid, iAcumA, iAcumB, iConst, iSelMux, iOp, iBranchDir, iFlush, iReady,
    input  oReady, oValid, oAluData, oBranchTaken, oBranchDir, oFlags
  );
endinterface

// File: rtl/ex_stage_pipe.sv
// Execute stage: single-cycle ALU/branch ops, multi-cycle shift-add MUL,
// one-entry output register with valid/ready handshake and flush.
module ex_stage_pipe #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 10
) (
  input  logic           iClock,
  input  logic           iReset_n,
  ex_stage_pipe_if.slave bus
);

  typedef enum logic [3:0] {
    OP_ADD = 4'd0,  OP_SUB = 4'd1,  OP_AND = 4'd2,  OP_OR  = 4'd3,
    OP_ASL = 4'd4,  OP_LSR = 4'd5,  OP_MUL = 4'd6,  OP_PASS = 4'd7,
    OP_BEQ = 4'd8,  OP_BNE = 4'd9,  OP_BCS = 4'd10, OP_BCC = 4'd11,
    OP_BMI = 4'd12, OP_BPL = 4'd13, OP_JMP = 4'd14, OP_NOP = 4'd15
  } op_e;

  typedef enum logic {S_IDLE, S_BUSY} state_e;

  localparam int CNT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(DATA_W - 1);

  state_e              r_state, w_state_nxt;
  logic                r_valid;
  logic [DATA_W-1:0]   r_alu;
  logic                r_taken;
  logic [ADDR_W-1:0]   r_dir;
  logic [2:0]          r_flags;    // {C,Z,N}
  logic [CNT_W-1:0]    r_cnt;
  logic [2*DATA_W-1:0] r_mcand;
  logic [DATA_W-1:0]   r_mplier;
  logic [2*DATA_W-1:0] r_prod;
  logic [ADDR_W-1:0]   r_mdir;

  logic [DATA_W-1:0]   w_oper1, w_oper2, w_res, w_mul_res;
  logic                w_c, w_upd, w_taken, w_mul_c;
  logic                w_out_free, w_ready, w_accept, w_is_mul, w_mul_done, w_load_single;
  logic [2*DATA_W-1:0] w_partial, w_prod_nxt;
  op_e                 w_op;

  assign w_op          = op_e'(bus.iOp);
  assign w_oper1       = bus.iSelMux[0] ? bus.iAcumA : bus.iConst;
  assign w_oper2       = bus.iSelMux[1] ? bus.iAcumB : bus.iConst;
  assign w_out_free    = !r_valid || bus.iReady;
  assign w_ready       = (r_state == S_IDLE) && w_out_free;
  assign w_accept      = bus.iValid && w_ready && !bus.iFlush;
  assign w_is_mul      = (w_op == OP_MUL);
  assign w_load_single = w_accept && !w_is_mul;
  // The last partial product is folded in on the completing edge, so the
  // counter parks at LAST_CNT while the output register is still occupied.
  assign w_mul_done    = (r_state == S_BUSY) && (r_cnt == LAST_CNT) && w_out_free && !bus.iFlush;

  assign w_partial  = r_mplier[0] ? r_mcand : '0;
  assign w_prod_nxt = r_prod + w_partial;
  assign w_mul_res  = w_prod_nxt[DATA_W-1:0];
  assign w_mul_c    = |w_prod_nxt[2*DATA_W-1:DATA_W];

  // Single-cycle result, carry and branch decision from the presented operands
  always_comb begin
    w_res   = '0;
    w_c     = 1'b0;
    w_upd   = 1'b0;
    w_taken = 1'b0;
    case (w_op)
      OP_ADD:  begin {w_c, w_res} = {1'b0, w_oper1} + {1'b0, w_oper2}; w_upd = 1'b1; end
      OP_SUB:  begin w_res = w_oper1 - w_oper2; w_c = (w_oper1 < w_oper2); w_upd = 1'b1; end
      OP_AND:  begin w_res = w_oper1 & w_oper2; w_upd = 1'b1; end
      OP_OR:   begin w_res = w_oper1 | w_oper2; w_upd = 1'b1; end
      OP_ASL:  begin w_res = w_oper1 << 1; w_c = w_oper1[DATA_W-1]; w_upd = 1'b1; end
      OP_LSR:  begin w_res = w_oper1 >> 1; w_c = w_oper1[0]; w_upd = 1'b1; end
      OP_PASS: begin w_res = w_oper2; w_upd = 1'b1; end
      OP_BEQ:  w_taken = (w_oper1 == '0);
      OP_BNE:  w_taken = (w_oper1 != '0);
      OP_BCS:  w_taken = r_flags[2];
      OP_BCC:  w_taken = !r_flags[2];
      OP_BMI:  w_taken = w_oper1[DATA_W-1];
      OP_BPL:  w_taken = !w_oper1[DATA_W-1];
      OP_JMP:  w_taken = 1'b1;
      default: ;
    endcase
  end

  // Next-state logic: MUL accept enters BUSY, completion or flush returns to IDLE
  always_comb begin
    w_state_nxt = r_state;
    if (bus.iFlush) begin
      w_state_nxt = S_IDLE;
    end else begin
      case (r_state)
        S_IDLE:  if (w_accept && w_is_mul) w_state_nxt = S_BUSY;
        S_BUSY:  if (w_mul_done) w_state_nxt = S_IDLE;
        default: w_state_nxt = S_IDLE;
      endcase
    end
  end

  // State register
  always_ff @(posedge iClock or negedge iReset_n) begin
    if (!iReset_n) r_state <= S_IDLE;
    else           r_state <= w_state_nxt;
  end

  // Shift-add multiplier: capture operands on accept, one step per BUSY edge
  always_ff @(posedge iClock or negedge iReset_n) begin
    if (!iReset_n) begin
      r_cnt    <= '0;
      r_mcand  <= '0;
      r_mplier <= '0;
      r_prod   <= '0;
      r_mdir   <= '0;
    end else if (bus.iFlush) begin
      r_cnt <= '0;
    end else if (w_accept && w_is_mul) begin
      r_cnt    <= '0;
      r_mcand  <= {{DATA_W{1'b0}}, w_oper1};
      r_mplier <= w_oper2;
      r_prod   <= '0;
      r_mdir   <= bus.iBranchDir;
    end else if (r_state == S_BUSY && r_cnt != LAST_CNT) begin
      r_prod   <= w_prod_nxt;
      r_mcand  <= r_mcand << 1;
      r_mplier <= r_mplier >> 1;
      r_cnt    <= r_cnt + CNT_W'(1);
    end else if (w_mul_done) begin
      r_cnt <= '0;
    end
  end

  // Output register and flags: load, hold under backpressure, drain, flush
  always_ff @(posedge iClock or negedge iReset_n) begin
    if (!iReset_n) begin
      r_valid <= 1'b0;
      r_alu   <= '0;
      r_taken <= 1'b0;
      r_dir   <= '0;
      r_flags <= '0;
    end else if (bus.iFlush) begin
      r_valid <= 1'b0;
    end else if (w_load_single) begin
      r_valid <= 1'b1;
      r_alu   <= w_res;
      r_taken <= w_taken;
      r_dir   <= bus.iBranchDir;
      if (w_upd) r_flags <= {w_c, (w_res == '0), w_res[DATA_W-1]};
    end else if (w_mul_done) begin
      r_valid <= 1'b1;
      r_alu   <= w_mul_res;
      r_taken <= 1'b0;
      r_dir   <= r_mdir;
      r_flags <= {w_mul_c, (w_mul_res == '0), w_mul_res[DATA_W-1]};
    end else if (r_valid && bus.iReady) begin
      r_valid <= 1'b0;
    end
  end

  assign bus.oReady       = w_ready;
  assign bus.oValid       = r_valid;
  assign bus.oAluData     = r_alu;
  assign bus.oBranchTaken = r_taken;
  assign bus.oBranchDir   = r_dir;
  assign bus.oFlags       = r_flags;

endmodule

// File: tb/tb_ex_stage_pipe.sv
// Directed bench for ex_stage_pipe with a result scoreboard and a small
// behavioural reference for results, flags and branch decisions.
module tb_ex_stage_pipe;
  localparam int DW = 8;
  localparam int AW = 10;

  typedef struct packed {
    logic [DW-1:0] data;
    logic          taken;
    logic [AW-1:0] dir;
    logic [2:0]    flags;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  ex_stage_pipe_if #(.DATA_W(DW), .ADDR_W(AW)) bus ();

  ex_stage_pipe #(.DATA_W(DW), .ADDR_W(AW)) dut (
    .iClock  (clk),
    .iReset_n(rst_n),
    .bus     (bus.slave)
  );

  exp_t       sbq[$];
  logic [2:0] m_flags;
  int         total = 0;
  int         bad   = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Reference behaviour; updates the model flag register as the result loads
  task automatic push_exp(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b,
                          input logic [7:0] k, input logic [1:0] sel, input logic [9:0] dir);
    logic [7:0]  o1, o2;
    logic [8:0]  s;
    logic [15:0] p;
    logic        c, upd;
    exp_t        e;
    o1 = sel[0] ? a : k;
    o2 = sel[1] ? b : k;
    c = 1'b0; upd = 1'b1;
    e.data = '0; e.taken = 1'b0; e.dir = dir;
    case (op)
      4'd0:  begin s = {1'b0, o1} + {1'b0, o2}; e.data = s[7:0]; c = s[8]; end
      4'd1:  begin e.data = o1 - o2; c = (o1 < o2); end
      4'd2:  e.data = o1 & o2;
      4'd3:  e.data = o1 | o2;
      4'd4:  begin e.data = {o1[6:0], 1'b0}; c = o1[7]; end
      4'd5:  begin e.data = {1'b0, o1[7:1]}; c = o1[0]; end
      4'd6:  begin p = 16'(o1) * 16'(o2); e.data = p[7:0]; c = (p[15:8] != 8'h00); end
      4'd7:  e.data = o2;
      4'd8:  begin upd = 1'b0; e.taken = (o1 == 8'h00); end
      4'd9:  begin upd = 1'b0; e.taken = (o1 != 8'h00); end
      4'd10: begin upd = 1'b0; e.taken = m_flags[2]; end
      4'd11: begin upd = 1'b0; e.taken = !m_flags[2]; end
      4'd12: begin upd = 1'b0; e.taken = o1[7]; end
      4'd13: begin upd = 1'b0; e.taken = !o1[7]; end
      4'd14: begin upd = 1'b0; e.taken = 1'b1; end
      default: upd = 1'b0;
    endcase
    if (upd) m_flags = {c, (e.data == 8'h00), e.data[7]};
    e.flags = m_flags;
    sbq.push_back(e);
  endtask

  task automatic drive(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b,
                       input logic [7:0] k, input logic [1:0] sel, input logic [9:0] dir);
    bus.iOp = op; bus.iAcumA = a; bus.iAcumB = b; bus.iConst = k;
    bus.iSelMux = sel; bus.iBranchDir = dir; bus.iValid = 1'b1;
  endtask

  task automatic issue(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b,
                       input logic [7:0] k, input logic [1:0] sel, input logic [9:0] dir);
    drive(op, a, b, k, sel, dir);
    push_exp(op, a, b, k, sel, dir);
    tick(1);
    bus.iValid = 1'b0;
  endtask

  // Compare the output register with the scoreboard head; optionally retire it
  task automatic check_head(input string tag, input bit pop);
    exp_t e;
    total++;
    assert (sbq.size() > 0) else begin
      bad++;
      $error("FAIL %s_sbq: observed=empty expected=entry", tag);
    end
    if (sbq.size() > 0) begin
      e = sbq[0];
      chk({tag, "_valid"}, 32'(bus.oValid), 32'd1);
      chk({tag, "_data"},  32'(bus.oAluData), 32'(e.data));
      chk({tag, "_taken"}, 32'(bus.oBranchTaken), 32'(e.taken));
      chk({tag, "_dir"},   32'(bus.oBranchDir), 32'(e.dir));
      chk({tag, "_flags"}, 32'(bus.oFlags), 32'(e.flags));
      if (pop) void'(sbq.pop_front());
    end
  endtask

  task automatic run_op(input string tag, input logic [3:0] op, input logic [7:0] a,
                        input logic [7:0] b, input logic [7:0] k, input logic [1:0] sel,
                        input logic [9:0] dir);
    issue(op, a, b, k, sel, dir);
    check_head(tag, 1'b1);
  endtask

  initial begin
    bus.iValid = 1'b0; bus.iAcumA = '0; bus.iAcumB = '0; bus.iConst = '0;
    bus.iSelMux = '0; bus.iOp = 4'd15; bus.iBranchDir = '0; bus.iFlush = 1'b0;
    bus.iReady = 1'b1;
    m_flags = '0;

    // Reset state
    #12;
    chk("rst_valid", 32'(bus.oValid), 32'd0);
    chk("rst_data",  32'(bus.oAluData), 32'd0);
    chk("rst_taken", 32'(bus.oBranchTaken), 32'd0);
    chk("rst_dir",   32'(bus.oBranchDir), 32'd0);
    chk("rst_flags", 32'(bus.oFlags), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("rst_ready", 32'(bus.oReady), 32'd1);
    tick(1);

    // ADD carry, SUB zero, BEQ taken, back to back
    run_op("add", 4'd0, 8'hF0, 8'h20, 8'h00, 2'b11, 10'h155);
    chk("add_lit_data",  32'(bus.oAluData), 32'h10);
    chk("add_lit_flags", 32'(bus.oFlags), 32'b100);
    run_op("sub", 4'd1, 8'h05, 8'h00, 8'h05, 2'b01, 10'h000);
    chk("sub_lit_flags", 32'(bus.oFlags), 32'b010);
    run_op("beq", 4'd8, 8'h00, 8'h00, 8'h00, 2'b01, 10'h2AB);
    chk("beq_lit_taken", 32'(bus.oBranchTaken), 32'd1);
    chk("beq_lit_dir",   32'(bus.oBranchDir), 32'h2AB);
    tick(1);
    chk("drain_valid", 32'(bus.oValid), 32'd0);

    // Remaining single-cycle ops and branch conditions
    run_op("or",   4'd3,  8'h81, 8'h00, 8'h40, 2'b01, 10'h003);
    run_op("and",  4'd2,  8'hF0, 8'h3C, 8'h00, 2'b11, 10'h004);
    run_op("asl",  4'd4,  8'h81, 8'h00, 8'h00, 2'b01, 10'h005);
    run_op("bcs",  4'd10, 8'h00, 8'h00, 8'h00, 2'b01, 10'h006);
    run_op("bcc",  4'd11, 8'h00, 8'h00, 8'h00, 2'b01, 10'h007);
    run_op("lsr",  4'd5,  8'h01, 8'h00, 8'h00, 2'b01, 10'h008);
    run_op("pass", 4'd7,  8'h00, 8'h80, 8'h11, 2'b11, 10'h009);
    run_op("bmi",  4'd12, 8'h80, 8'h00, 8'h00, 2'b01, 10'h00A);
    run_op("bpl",  4'd13, 8'h80, 8'h00, 8'h00, 2'b01, 10'h00B);
    run_op("bne",  4'd9,  8'h00, 8'h00, 8'h05, 2'b00, 10'h00C);
    run_op("jmp",  4'd14, 8'h00, 8'h00, 8'h00, 2'b00, 10'h00D);
    run_op("nop",  4'd15, 8'h55, 8'h00, 8'h00, 2'b01, 10'h00E);
    run_op("addz", 4'd0,  8'hFF, 8'h01, 8'h00, 2'b11, 10'h00F);
    tick(1);

    // MUL latency, oReady low while busy, inputs ignored while busy
    issue(4'd6, 8'h12, 8'h34, 8'h00, 2'b11, 10'h3C3);
    drive(4'd0, 8'hFF, 8'hFF, 8'hFF, 2'b11, 10'h111);
    for (int k = 0; k < 8; k++) begin
      chk($sformatf("mul_busy_ready%0d", k), 32'(bus.oReady), 32'd0);
      chk($sformatf("mul_busy_valid%0d", k), 32'(bus.oValid), 32'd0);
      tick(1);
    end
    bus.iValid = 1'b0;
    check_head("mul", 1'b1);
    chk("mul_lit_data",  32'(bus.oAluData), 32'hA8);
    chk("mul_lit_flags", 32'(bus.oFlags), 32'b101);
    chk("mul_ready_after", 32'(bus.oReady), 32'd1);
    tick(1);
    chk("mul_drain", 32'(bus.oValid), 32'd0);

    // Backpressure: hold, then drain and reload on the same edge
    bus.iReady = 1'b0;
    issue(4'd0, 8'h01, 8'h02, 8'h00, 2'b11, 10'h010);
    drive(4'd0, 8'h10, 8'h20, 8'h00, 2'b11, 10'h011);
    push_exp(4'd0, 8'h10, 8'h20, 8'h00, 2'b11, 10'h011);
    chk("bp_ready0", 32'(bus.oReady), 32'd0);
    check_head("bp_hold0", 1'b0);
    tick(1);
    chk("bp_ready1", 32'(bus.oReady), 32'd0);
    check_head("bp_hold1", 1'b0);
    bus.iReady = 1'b1;
    #1;
    chk("bp_ready2", 32'(bus.oReady), 32'd1);
    void'(sbq.pop_front());
    tick(1);
    bus.iValid = 1'b0;
    check_head("bp_new", 1'b1);
    tick(1);
    chk("bp_drain", 32'(bus.oValid), 32'd0);

    // Flush of a held result; flush racing an accept
    bus.iReady = 1'b0;
    issue(4'd0, 8'h7F, 8'h01, 8'h00, 2'b11, 10'h012);
    check_head("fl_pre", 1'b0);
    bus.iFlush = 1'b1;
    tick(1);
    bus.iFlush = 1'b0;
    chk("fl_valid", 32'(bus.oValid), 32'd0);
    chk("fl_flags", 32'(bus.oFlags), 32'(m_flags));
    void'(sbq.pop_front());
    bus.iReady = 1'b1;
    drive(4'd0, 8'h01, 8'h01, 8'h00, 2'b11, 10'h013);
    bus.iFlush = 1'b1;
    tick(1);
    bus.iValid = 1'b0;
    bus.iFlush = 1'b0;
    chk("fl_acc_valid", 32'(bus.oValid), 32'd0);
    chk("fl_acc_flags", 32'(bus.oFlags), 32'(m_flags));

    // Flush three cycles into a MUL
    drive(4'd6, 8'h0F, 8'h0F, 8'h00, 2'b11, 10'h014);
    tick(1);
    bus.iValid = 1'b0;
    tick(2);
    bus.iFlush = 1'b1;
    tick(1);
    bus.iFlush = 1'b0;
    chk("flm_valid", 32'(bus.oValid), 32'd0);
    chk("flm_ready", 32'(bus.oReady), 32'd1);
    chk("flm_flags", 32'(bus.oFlags), 32'(m_flags));
    tick(10);
    chk("flm_late_valid", 32'(bus.oValid), 32'd0);
    chk("flm_late_flags", 32'(bus.oFlags), 32'(m_flags));
    run_op("flm_after", 4'd0, 8'h02, 8'h03, 8'h00, 2'b11, 10'h015);

    // Asynchronous reset three cycles into a MUL, with nonzero outputs beforehand
    run_op("pre_rst", 4'd0, 8'hFF, 8'hFF, 8'h00, 2'b11, 10'h3FF);
    drive(4'd6, 8'h03, 8'h05, 8'h00, 2'b11, 10'h016);
    tick(1);
    bus.iValid = 1'b0;
    tick(2);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_valid", 32'(bus.oValid), 32'd0);
    chk("arst_data",  32'(bus.oAluData), 32'd0);
    chk("arst_taken", 32'(bus.oBranchTaken), 32'd0);
    chk("arst_dir",   32'(bus.oBranchDir), 32'd0);
    chk("arst_flags", 32'(bus.oFlags), 32'd0);
    m_flags = '0;
    sbq.delete();
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("arst_ready", 32'(bus.oReady), 32'd1);
    tick(10);
    chk("arst_no_mul", 32'(bus.oValid), 32'd0);
    run_op("post_rst", 4'd1, 8'h03, 8'h00, 8'h05, 2'b01, 10'h017);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/ex_stage_pipe.md
EX_STAGE_PIPE -- requirements
Module: ex_stage_pipe

Interface
REQ-001 Parameter DATA_W, default 8: operand/result width.
REQ-002 Parameter ADDR_W, default 10: branch-target width.
REQ-003 iClock  in  1  sole clock; all state updates on rising edge.
REQ-004 iReset_n  in  1  reset, asynchronous, active-low.
REQ-005 iValid  in  1  upstream holds a valid operation.
REQ-006 oReady  out  1  stage accepts an operation this cycle.
REQ-007 iAcumA, iAcumB, iConst  in  DATA_W each  accumulator A, accumulator B, immediate.
REQ-008 iSelMux  in  2  bit0=1: oper1=iAcumA, else iConst; bit1=1: oper2=iAcumB, else iConst.
REQ-009 iOp  in  4  0 ADD, 1 SUB, 2 AND, 3 OR, 4 ASL, 5 LSR, 6 MUL, 7 PASS, 8 BEQ, 9 BNE, 10 BCS, 11 BCC, 12 BMI, 13 BPL, 14 JMP, 15 NOP.
REQ-010 iBranchDir  in  ADDR_W  branch target.
REQ-011 iFlush  in  1  discard in-flight and output-register contents.
REQ-012 iReady  in  1  downstream accepts oValid data.
REQ-013 oValid  out  1  output register holds a result.
REQ-014 oAluData  out  DATA_W  registered result.
REQ-015 oBranchTaken  out  1  registered branch decision.
REQ-016 oBranchDir  out  ADDR_W  registered copy of iBranchDir.
REQ-017 oFlags  out  3  {C,Z,N} flag register.

Function
- REQ-018 Accept = iValid && oReady; oReady = (state==IDLE) && (!oValid || iReady).
- REQ-019 Single-cycle ops (all except MUL): result, oBranchTaken, oBranchDir loaded into the output register on the accept edge; oValid=1 the next cycle (latency 1).
- REQ-020 oValid clears on the edge where oValid && iReady and no new result loads; a simultaneous new load keeps oValid=1 with the new data.
- REQ-021 Output register holds all outputs stable while oValid && !iReady.
- REQ-022 Arithmetic modulo 2^DATA_W; ADD C=carry-out; SUB C=1 iff oper1<oper2 (borrow); AND/OR/PASS C=0; ASL shifts oper1 left by 1, C=old MSB; LSR shifts oper1 right by 1 with 0 in, C=old LSB; PASS result=oper2.
- REQ-023 Flags update only when ADD, SUB, AND, OR, ASL, LSR, MUL, PASS results load: Z=(result==0), N=result MSB.
- REQ-024 Branches, JMP, NOP leave flags unchanged; oAluData=0.
- REQ-025 Branch conditions: BEQ oper1==0, BNE oper1!=0, BMI oper1 MSB=1, BPL oper1 MSB=0, BCS C=1, BCC C=0 (C = current flag register); JMP always; others 0.
- REQ-026 MUL: states IDLE->BUSY on accept; shift-add over exactly DATA_W cycles, BUSY->IDLE, result = low DATA_W bits of oper1*oper2 loaded on the final BUSY edge; latency DATA_W+1 edges from accept to oValid.
- REQ-027 MUL C=1 iff upper DATA_W product bits are nonzero.
- REQ-028 Operands are captured on accept; input changes during BUSY have no effect; oReady=0 throughout BUSY.
- REQ-029 MUL completion while oValid && !iReady: remain in BUSY at final count until the output register frees, then load.
- REQ-030 iFlush: next edge oValid=0, state=IDLE, in-flight MUL discarded, flags unchanged; an accept in the same cycle is discarded.

Reset
- REQ-031 iReset_n low asynchronously forces state=IDLE, oValid=0, oAluData=0, oBranchTaken=0, oBranchDir=0, oFlags=0, multiply counter=0; effective mid-MUL.
- REQ-032 oReady=1 the first cycle after reset release (iReady irrelevant since oValid=0).

Verification
- REQ-033 DATA_W=8, ADD iSelMux=11, A=0xF0, B=0x20, iReady=1 -> one cycle later oValid=1, oAluData=0x10, oFlags={1,0,0}.
- REQ-034 SUB A=0x05, const=0x05, iSelMux=01 -> oAluData=0x00, flags={0,1,0}; then BEQ with A=0 -> oBranchTaken=1, oBranchDir=iBranchDir, flags unchanged.
- REQ-035 MUL A=0x12, B=0x34 -> oReady=0 for 8 cycles, oValid on 9th edge, oAluData=0xA8, C=1 (product 0x03A8).
- REQ-036 iReady=0 with oValid=1, new ADD presented -> oReady=0, outputs frozen; iReady=1 -> old result drains, new ADD loads same edge, oValid stays 1.
- REQ-037 Reset asserted 3 cycles into MUL -> all outputs 0 immediately; post-release oReady=1; iFlush 3 cycles into MUL -> oValid stays 0, state IDLE, flags unchanged.
